updi_cs_sequencer: RTL and testbench

UPDI_CS_SEQUENCER -- requirements
Module: updi_cs_sequencer

---
 rtl/updi_cs_if.sv | 22 ++
 rtl/updi_cs_sequencer.sv | 162 ++++++++++++++++
 tb/tb_updi_cs_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updi_cs_if.sv
// CS-command channel between the sequencer (master) and the UPDI link layer (slave).
interface updi_cs_if;
    // A command moves on each rising edge where cmd_valid && cmd_ready. Once raised,
    // cmd_valid and the command fields hold until that edge. rsp_valid has no ready.
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_is_store;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_is_store, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_is_store, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/updi_cs_sequencer.sv
// Walks a ROM table of STCS/CHECK/POLL/END steps, issuing CS commands and
// checking LDCS responses with retry, delay and timeout handling.
module updi_cs_sequencer #(
    parameter int N_STEPS          = 16,
    parameter int STEP_ADDR_BITS   = $clog2(N_STEPS),
    parameter int MAX_RETRIES      = 255,
    parameter int RETRY_DELAY_CLKS = 100,
    parameter int RSP_TIMEOUT_CLKS = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [STEP_ADDR_BITS-1:0] err_step,
    output logic [STEP_ADDR_BITS-1:0] step_addr,
    input  logic [21:0]               step_data,
    updi_cs_if.master                 cs,
    output logic [2:0]                state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_RSP, S_EVAL, S_DELAY, S_FINISH
    } state_t;

    localparam logic [1:0] OP_STCS  = 2'b00;
    localparam logic [1:0] OP_CHECK = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    // One counter serves both the response timeout and the retry delay.
    localparam int CNT_MAX = (RSP_TIMEOUT_CLKS > RETRY_DELAY_CLKS) ? RSP_TIMEOUT_CLKS
                                                                   : RETRY_DELAY_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

    localparam logic [CNT_W-1:0]          TO_LAST   = CNT_W'(RSP_TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0]          DLY_LAST  = CNT_W'(RETRY_DELAY_CLKS - 1);
    localparam logic [RETRY_W-1:0]        RETRY_LIM = RETRY_W'(MAX_RETRIES);
    localparam logic [STEP_ADDR_BITS-1:0] IDX_LAST  = STEP_ADDR_BITS'(N_STEPS - 1);

    state_t                    state, nxt;
    logic [STEP_ADDR_BITS-1:0] idx;
    logic [21:0]               step_q;
    logic [CNT_W-1:0]          cnt;
    logic [RETRY_W-1:0]        retry;
    logic [7:0]                rsp_q;
    logic                      fail_now;
    logic [1:0]                fail_code;

    logic [1:0] op;
    logic [3:0] f_addr;
    logic [7:0] f_value, f_mask;
    logic       match;

    assign op      = step_q[1:0];
    assign f_addr  = step_q[5:2];
    assign f_value = step_q[13:6];
    assign f_mask  = step_q[21:14];
    assign match   = ((rsp_q & f_mask) == (f_value & f_mask));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt       = state;
        fail_now  = 1'b0;
        fail_code = 2'b00;
        case (state)
            S_IDLE:   if (start) nxt = S_FETCH;
            S_FETCH:  nxt = S_LATCH;
            S_LATCH:  nxt = (step_data[1:0] == OP_END) ? S_FINISH : S_ISSUE;
            S_ISSUE:  if (cs.cmd_ready) nxt = (op == OP_STCS) ? S_EVAL : S_WAIT_RSP;
            S_WAIT_RSP: begin
                if (cs.rsp_valid) begin
                    nxt = S_EVAL;
                end else if (cnt == TO_LAST) begin
                    nxt       = S_FINISH;
                    fail_now  = 1'b1;
                    fail_code = 2'b11;
                end
            end
            S_EVAL: begin
                // Passing the last table slot ends the run rather than wrapping to step 0.
                if (op == OP_STCS || match) begin
                    nxt = (idx == IDX_LAST) ? S_FINISH : S_FETCH;
                end else if (op == OP_POLL && retry < RETRY_LIM) begin
                    nxt = S_DELAY;
                end else begin
                    nxt       = S_FINISH;
                    fail_now  = 1'b1;
                    fail_code = (op == OP_POLL) ? 2'b10 : 2'b01;
                end
            end
            S_DELAY:  if (cnt == DLY_LAST) nxt = S_ISSUE;
            S_FINISH: nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            step_q   <= '0;
            cnt      <= '0;
            retry    <= '0;
            rsp_q    <= '0;
            err_code <= 2'b00;
            err_step <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        err_code <= 2'b00;
                        err_step <= '0;
                    end
                end
                S_LATCH: begin
                    step_q <= step_data;
                    retry  <= '0;
                end
                S_ISSUE: cnt <= '0;
                S_WAIT_RSP: begin
                    if (cs.rsp_valid) rsp_q <= cs.rsp_data;
                    else              cnt   <= cnt + 1'b1;
                end
                S_EVAL: begin
                    if (nxt == S_FETCH) idx <= idx + 1'b1;
                    if (nxt == S_DELAY) begin
                        retry <= retry + 1'b1;
                        cnt   <= '0;
                    end
                end
                S_DELAY: cnt <= cnt + 1'b1;
                default: ;
            endcase
            if (fail_now) begin
                err_code <= fail_code;
                err_step <= idx;
            end
        end
    end

    // err_code is cleared on start and only set on failure, so it tells done from error.
    always_comb begin
        busy            = (state != S_IDLE);
        done            = (state == S_FINISH) && (err_code == 2'b00);
        error           = (state == S_FINISH) && (err_code != 2'b00);
        cs.cmd_valid    = (state == S_ISSUE);
        cs.cmd_is_store = (op == OP_STCS);
        cs.cmd_addr     = f_addr;
        cs.cmd_wdata    = f_value;
        step_addr       = idx;
        state_dbg       = state;
    end

endmodule

// File: tb/tb_updi_cs_sequencer.sv
// Directed and randomized bench for updi_cs_sequencer with a table-walking reference model.
module tb_updi_cs_sequencer;
    localparam int N    = 16;
    localparam int AW   = 4;
    localparam int MAXR = 2;
    localparam int DLY  = 4;
    localparam int TO   = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, busy, done, error;
    logic [1:0]    err_code;
    logic [AW-1:0] err_step, step_addr;
    logic [21:0]   step_data;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    updi_cs_if cs();

    updi_cs_sequencer #(
        .N_STEPS(N), .STEP_ADDR_BITS(AW), .MAX_RETRIES(MAXR),
        .RETRY_DELAY_CLKS(DLY), .RSP_TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .err_step(err_step),
        .step_addr(step_addr), .step_data(step_data), .cs(cs), .state_dbg(state_dbg)
    );

    // Synchronous step ROM.
    logic [21:0] rom [N];
    always @(posedge clk) step_data <= rom[step_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         dly;
        logic [7:0] data;
    } rsp_t;

    rsp_t        plan_q[$];
    logic [12:0] exp_q[$];
    int          xfer_cyc_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          ready_pct = 100;
    int          hold_left = 0;
    int          rsp_due = -1;
    logic [7:0]  rsp_val = 8'h00;
    logic        prev_pend = 1'b0;
    logic [12:0] prev_f = '0;
    int          fin_cyc = 0;

    function automatic logic [21:0] enc(logic [1:0] op, logic [3:0] a, logic [7:0] v,
                                        logic [7:0] m);
        return {m, v, a, op};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic fill_end();
        for (int i = 0; i < N; i++) rom[i] = enc(2'b11, 4'h0, 8'h00, 8'h00);
    endtask

    // Reference: walk the table by its rules, consuming planned responses per LDCS.
    function automatic void model_run(output logic [1:0] code, output int fstep);
        int          idx, pi, tries;
        logic [21:0] w;
        rsp_t        p;
        code = 2'b00; fstep = 0; idx = 0; pi = 0;
        while (1) begin
            w = rom[idx];
            if (w[1:0] == 2'b11) return;
            if (w[1:0] == 2'b00) begin
                exp_q.push_back({1'b1, w[5:2], w[13:6]});
            end else begin
                tries = 0;
                while (1) begin
                    exp_q.push_back({1'b0, w[5:2], w[13:6]});
                    if (pi < plan_q.size()) p = plan_q[pi];
                    else begin p.dly = 0; p.data = 8'h00; end
                    pi++;
                    if (p.dly == 0 || p.dly > TO) begin code = 2'b11; fstep = idx; return; end
                    if ((p.data & w[21:14]) == (w[13:6] & w[21:14])) break;
                    if (w[1:0] == 2'b01) begin code = 2'b01; fstep = idx; return; end
                    if (tries == MAXR) begin code = 2'b10; fstep = idx; return; end
                    tries++;
                end
            end
            if (idx == N - 1) return;
            idx++;
        end
    endfunction

    // Link-layer responder and command scoreboard; acts on falling edges.
    initial begin : responder
        logic [12:0] f;
        rsp_t        p;
        cs.cmd_ready = 1'b0;
        cs.rsp_valid = 1'b0;
        cs.rsp_data  = 8'h00;
        forever begin
            @(negedge clk);
            f = {cs.cmd_is_store, cs.cmd_addr, cs.cmd_wdata};
            if (prev_pend) begin
                check("cmd_valid_held", 32'(cs.cmd_valid), 32'd1);
                check("cmd_fields_held", 32'(f), 32'(prev_f));
            end
            cs.rsp_valid = (rsp_due == cyc);
            cs.rsp_data  = (rsp_due == cyc) ? rsp_val : 8'($urandom);
            if (hold_left > 0 && cs.cmd_valid) begin
                cs.cmd_ready = 1'b0;
                hold_left--;
            end else begin
                cs.cmd_ready = ($urandom_range(99) < ready_pct);
            end
            if (cs.cmd_valid && cs.cmd_ready) begin
                xfer_cyc_q.push_back(cyc);
                check("cmd", 32'(f), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF);
                if (!cs.cmd_is_store && plan_q.size() > 0) begin
                    p = plan_q.pop_front();
                    if (p.dly != 0) begin
                        rsp_due = cyc + p.dly;
                        rsp_val = p.data;
                    end
                end
            end
            prev_pend = cs.cmd_valid && !cs.cmd_ready;
            prev_f    = f;
        end
    end

    task automatic wait_finish(input bit rand_start);
        for (int i = 0; i < 3000; i++) begin
            if (done || error) break;
            @(negedge clk);
            if (rand_start) start = 1'($urandom_range(1));
        end
        start   = 1'b0;
        fin_cyc = cyc;
        check("finish_seen", 32'(done | error), 32'd1);
    endtask

    task automatic run_seq(input string tag, input logic [1:0] ecode, input int estep,
                           input bit rand_start);
        xfer_cyc_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_finish(rand_start);
        check({tag, "_done"}, 32'(done), 32'(ecode == 2'b00));
        check({tag, "_error"}, 32'(error), 32'(ecode != 2'b00));
        check({tag, "_err_code"}, 32'(err_code), 32'(ecode));
        if (ecode != 2'b00) check({tag, "_err_step"}, 32'(err_step), 32'(estep));
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_pulse_width"}, 32'(done | error), 32'd0);
        check({tag, "_err_code_held"}, 32'(err_code), 32'(ecode));
        check({tag, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [7:0] pick4();
        case ($urandom_range(3))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h0F;
            default: return 8'hF0;
        endcase
    endfunction

    initial begin : main
        logic [1:0] ecode;
        int         estep, t;
        rsp_t       p;

        rst_n = 1'b0;
        start = 1'b0;
        fill_end();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cmd_valid", 32'(cs.cmd_valid), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_err_step", 32'(err_step), 32'd0);
        check("rst_step_addr", 32'(step_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two stores then END.
        fill_end();
        rom[0] = enc(2'b00, 4'h8, 8'h59, 8'h00);
        rom[1] = enc(2'b00, 4'h8, 8'h00, 8'h00);
        exp_q = '{13'h1859, 13'h1800};
        run_seq("stcs", 2'b00, 0, 1'b0);

        // CHECK mismatch.
        fill_end();
        rom[0] = enc(2'b01, 4'h0, 8'h00, 8'hFF);
        plan_q.delete(); p.dly = 1; p.data = 8'h30; plan_q.push_back(p);
        exp_q = '{13'h0000};
        run_seq("check_mis", 2'b01, 0, 1'b1);

        // Two matching CHECKs, response 3 clocks after transfer: 4+3 clocks per step.
        fill_end();
        rom[0] = enc(2'b01, 4'h2, 8'h5A, 8'hFF);
        rom[1] = enc(2'b01, 4'h3, 8'hA0, 8'hF0);
        plan_q.delete();
        p.dly = 3; p.data = 8'h5A; plan_q.push_back(p);
        p.dly = 3; p.data = 8'hA7; plan_q.push_back(p);
        exp_q = '{13'h025A, 13'h03A0};
        run_seq("lat", 2'b00, 0, 1'b0);
        check("lat_gap", 32'((xfer_cyc_q.size() >= 2) ? xfer_cyc_q[1] - xfer_cyc_q[0] : -1), 32'd7);

        // POLL succeeding on the third read; reads spaced by rsp(1)+EVAL+DELAY(4)+ISSUE.
        fill_end();
        rom[0] = enc(2'b10, 4'hB, 8'h00, 8'h01);
        plan_q.delete();
        p.dly = 1; p.data = 8'h01; plan_q.push_back(p); plan_q.push_back(p);
        p.data = 8'h00; plan_q.push_back(p);
        exp_q = '{13'h0B00, 13'h0B00, 13'h0B00};
        run_seq("poll", 2'b00, 0, 1'b0);
        check("poll_reads", 32'(xfer_cyc_q.size()), 32'd3);
        check("poll_gap1", 32'((xfer_cyc_q.size() >= 3) ? xfer_cyc_q[1] - xfer_cyc_q[0] : -1), 32'd7);
        check("poll_gap2", 32'((xfer_cyc_q.size() >= 3) ? xfer_cyc_q[2] - xfer_cyc_q[1] : -1), 32'd7);

        // POLL never matching at step 2: 1 + MAXR reads then retries-exhausted.
        fill_end();
        rom[0] = enc(2'b00, 4'h1, 8'hAA, 8'h00);
        rom[1] = enc(2'b00, 4'h2, 8'h55, 8'h00);
        rom[2] = enc(2'b10, 4'hC, 8'h80, 8'h80);
        plan_q.delete();
        p.dly = 2; p.data = 8'h00;
        repeat (3) plan_q.push_back(p);
        exp_q = '{13'h11AA, 13'h1255, 13'h0C80, 13'h0C80, 13'h0C80};
        run_seq("poll_exh", 2'b10, 2, 1'b0);

        // No response, cmd_ready held low 5 clocks: error after 8 WAIT_RSP clocks.
        fill_end();
        rom[0] = enc(2'b01, 4'h5, 8'h12, 8'hFF);
        plan_q.delete(); p.dly = 0; p.data = 8'h00; plan_q.push_back(p);
        exp_q = '{13'h0512};
        hold_left = 5;
        run_seq("timeout", 2'b11, 0, 1'b0);
        check("timeout_cycles", 32'((xfer_cyc_q.size() >= 1) ? fin_cyc - xfer_cyc_q[0] : -1), 32'd9);

        // Full table of stores with no END: finish at the last slot.
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            rom[i] = enc(2'b00, 4'(i), 8'(i * 3), 8'h00);
            exp_q.push_back({1'b1, 4'(i), 8'(i * 3)});
        end
        run_seq("wrap", 2'b00, 0, 1'b0);

        // Reset during DELAY abandons silently; next start replays from step 0.
        fill_end();
        rom[0] = enc(2'b00, 4'h3, 8'h11, 8'h00);
        rom[1] = enc(2'b10, 4'hB, 8'h00, 8'h01);
        plan_q.delete(); p.dly = 1; p.data = 8'h01; plan_q.push_back(p);
        exp_q = '{13'h1311, 13'h0B00};
        xfer_cyc_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 200 && xfer_cyc_q.size() < 2; i++) @(negedge clk);
        t = (xfer_cyc_q.size() >= 2) ? xfer_cyc_q[1] : cyc;
        for (int i = 0; i < 50 && cyc < t + 4; i++) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_valid", 32'(cs.cmd_valid), 32'd0);
        check("mid_rst_err_code", 32'(err_code), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst_n = 1'b1;
            check("mid_rst_no_pulse", 32'(done | error), 32'd0);
            @(negedge clk);
        end
        check("mid_rst_idle", 32'(busy), 32'd0);
        check("mid_rst_cmds_left", 32'(exp_q.size()), 32'd0);
        plan_q.delete(); p.dly = 1; p.data = 8'h00; plan_q.push_back(p);
        exp_q = '{13'h1311, 13'h0B00};
        run_seq("replay", 2'b00, 0, 1'b0);

        // Randomized tables, responses and ready behaviour against the model.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                int         k;
                logic [1:0] op;
                logic [7:0] m;
                k  = int'($urandom_range(99));
                op = (k < 35) ? 2'b00 : (k < 60) ? 2'b01 : (k < 93) ? 2'b10 : 2'b11;
                m  = ($urandom_range(4) == 0) ? 8'($urandom) : pick4();
                rom[i] = enc(op, 4'($urandom), pick4(), m);
            end
            plan_q.delete();
            for (int i = 0; i < 64; i++) begin
                p.dly  = ($urandom_range(19) == 0) ? 0 : int'($urandom_range(1, TO + 1));
                p.data = ($urandom_range(4) == 0) ? 8'($urandom) : pick4();
                plan_q.push_back(p);
            end
            exp_q.delete();
            model_run(ecode, estep);
            ready_pct = int'($urandom_range(30, 100));
            run_seq($sformatf("rand%0d", r), ecode, estep, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
